// File: rtl/fmc_adc_frame_aligner.sv
// FMC ADC frame aligner.
// Compares the deserialised FR word with the expected frame pattern and
// issues bitslip requests until the pattern is seen on enough consecutive
// cycles. Once locked, sample data is flagged valid. If the frame is lost,
// the block re-searches on its own. It raises a sticky failure flag when a
// full rotation of slips gives no lock.
module fmc_adc_frame_aligner #(
   parameter int unsigned        g_WIDTH         = 8,
   parameter logic [g_WIDTH-1:0] g_FRAME_PATTERN = g_WIDTH'(8'h0F),
   parameter int unsigned        g_DATA_WIDTH    = 64,
   parameter int unsigned        g_LOCK_COUNT    = 16,
   parameter int unsigned        g_SLIP_WAIT     = 4,
   parameter int unsigned        g_UNLOCK_COUNT  = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic                    enable_i,
   input  logic [g_WIDTH-1:0]      frame_i,
   input  logic [g_DATA_WIDTH-1:0] data_i,
   output logic                    bitslip_o,
   output logic                    locked_o,
   output logic [g_DATA_WIDTH-1:0] data_o,
   output logic                    data_valid_o,
   output logic [3:0]              slip_cnt_o,
   output logic                    lock_lost_o,
   output logic                    fail_o
);

   // Counter widths are sized so that each counter can hold its terminal value.
   localparam int unsigned MATCH_W = $clog2(g_LOCK_COUNT + 1);
   localparam int unsigned ATT_W   = $clog2(g_WIDTH + 1);
   localparam int unsigned MISS_W  = $clog2(g_UNLOCK_COUNT + 1);
   localparam int unsigned WAIT_W  = $clog2(g_SLIP_WAIT + 1);

   // Terminal values: a counter at its "last" value completes its event on the
   // current cycle.
   localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(g_LOCK_COUNT - 1);
   localparam logic [ATT_W-1:0]   ATT_LAST   = ATT_W'(g_WIDTH - 1);
   localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(g_UNLOCK_COUNT - 1);
   localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(g_SLIP_WAIT - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CHECK  = 3'd1,
      ST_SLIP   = 3'd2,
      ST_WAIT   = 3'd3,
      ST_LOCKED = 3'd4
   } state_t;

   state_t                  state_r;
   logic [MATCH_W-1:0]      match_cnt_r;
   logic [ATT_W-1:0]        attempt_cnt_r;
   logic [MISS_W-1:0]       miss_cnt_r;
   logic [WAIT_W-1:0]       wait_cnt_r;
   logic [3:0]              slip_cnt_r;
   logic                    bitslip_r;
   logic                    locked_r;
   logic                    data_valid_r;
   logic                    lock_lost_r;
   logic                    fail_r;
   logic [g_DATA_WIDTH-1:0] data_r;

   logic                    frame_match_s;
   logic                    lost_event_s;

   // Frame comparison and loss-of-lock detection for the current cycle.
   always_comb begin
      frame_match_s = (frame_i == g_FRAME_PATTERN);
      lost_event_s  = 1'b0;
      if ((state_r == ST_LOCKED) && !frame_match_s && (miss_cnt_r == MISS_LAST)) begin
         lost_event_s = 1'b1;
      end else begin
         lost_event_s = 1'b0;
      end
   end

   // Alignment FSM. All status outputs are registered here.
   // A low enable wins over every transition except the loss-of-lock pulse.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_r       <= ST_IDLE;
         match_cnt_r   <= '0;
         attempt_cnt_r <= '0;
         miss_cnt_r    <= '0;
         wait_cnt_r    <= '0;
         slip_cnt_r    <= 4'd0;
         bitslip_r     <= 1'b0;
         locked_r      <= 1'b0;
         data_valid_r  <= 1'b0;
         lock_lost_r   <= 1'b0;
         fail_r        <= 1'b0;
      end else begin
         // The loss pulse is reported even when enable drops on the same cycle.
         lock_lost_r <= lost_event_s;
         bitslip_r   <= 1'b0;
         if (!enable_i) begin
            state_r       <= ST_IDLE;
            match_cnt_r   <= '0;
            attempt_cnt_r <= '0;
            miss_cnt_r    <= '0;
            wait_cnt_r    <= '0;
            slip_cnt_r    <= 4'd0;
            locked_r      <= 1'b0;
            data_valid_r  <= 1'b0;
            fail_r        <= 1'b0;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  state_r       <= ST_CHECK;
                  match_cnt_r   <= '0;
                  attempt_cnt_r <= '0;
                  miss_cnt_r    <= '0;
                  wait_cnt_r    <= '0;
                  locked_r      <= 1'b0;
                  data_valid_r  <= 1'b0;
               end
               ST_CHECK: begin
                  if (frame_match_s) begin
                     if (match_cnt_r == MATCH_LAST) begin
                        // This match completes the run: declare lock.
                        state_r      <= ST_LOCKED;
                        match_cnt_r  <= '0;
                        miss_cnt_r   <= '0;
                        locked_r     <= 1'b1;
                        data_valid_r <= 1'b1;
                     end else begin
                        match_cnt_r <= match_cnt_r + MATCH_W'(1);
                     end
                  end else begin
                     // Mismatch: request one slip. The slip counters move
                     // with the pulse so that software sees them together.
                     state_r     <= ST_SLIP;
                     match_cnt_r <= '0;
                     bitslip_r   <= 1'b1;
                     slip_cnt_r  <= slip_cnt_r + 4'd1;
                     if (attempt_cnt_r == ATT_LAST) begin
                        fail_r        <= 1'b1;
                        attempt_cnt_r <= '0;
                     end else begin
                        attempt_cnt_r <= attempt_cnt_r + ATT_W'(1);
                     end
                  end
               end
               ST_SLIP: begin
                  state_r    <= ST_WAIT;
                  wait_cnt_r <= '0;
               end
               ST_WAIT: begin
                  // Ignore frame_i while the deserialiser applies the slip.
                  if (wait_cnt_r == WAIT_LAST) begin
                     state_r    <= ST_CHECK;
                     wait_cnt_r <= '0;
                  end else begin
                     wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
                  end
               end
               ST_LOCKED: begin
                  attempt_cnt_r <= '0;
                  if (frame_match_s) begin
                     miss_cnt_r <= '0;
                  end else if (lost_event_s) begin
                     state_r      <= ST_CHECK;
                     match_cnt_r  <= '0;
                     miss_cnt_r   <= '0;
                     locked_r     <= 1'b0;
                     data_valid_r <= 1'b0;
                  end else begin
                     miss_cnt_r <= miss_cnt_r + MISS_W'(1);
                  end
               end
               default: begin
                  state_r       <= ST_IDLE;
                  match_cnt_r   <= '0;
                  attempt_cnt_r <= '0;
                  miss_cnt_r    <= '0;
                  wait_cnt_r    <= '0;
                  locked_r      <= 1'b0;
                  data_valid_r  <= 1'b0;
               end
            endcase
         end
      end
   end

   // Sample data path: a single register stage, independent of alignment state.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         data_r <= '0;
      end else begin
         data_r <= data_i;
      end
   end

   assign bitslip_o    = bitslip_r;
   assign locked_o     = locked_r;
   assign data_valid_o = data_valid_r;
   assign lock_lost_o  = lock_lost_r;
   assign fail_o       = fail_r;
   assign slip_cnt_o   = slip_cnt_r;
   assign data_o       = data_r;

endmodule

// File: tb/tb_fmc_adc_frame_aligner.sv
// Directed testbench for fmc_adc_frame_aligner.
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_fmc_adc_frame_aligner;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic [7:0]  frame;
   logic [63:0] data_in;
   logic        bitslip;
   logic        locked;
   logic [63:0] data_out;
   logic        data_valid;
   logic [3:0]  slip_cnt;
   logic        lock_lost;
   logic        fail;

   int          checks;
   int          errors;
   logic [63:0] data_exp;

   fmc_adc_frame_aligner dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .enable_i     (enable),
      .frame_i      (frame),
      .data_i       (data_in),
      .bitslip_o    (bitslip),
      .locked_o     (locked),
      .data_o       (data_out),
      .data_valid_o (data_valid),
      .slip_cnt_o   (slip_cnt),
      .lock_lost_o  (lock_lost),
      .fail_o       (fail)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      logic [7:0] r;
      r = x;
      for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
      return r;
   endfunction

   // Advance one clock.
   // On return, data_out should equal data_exp, the data_in value the DUT sampled.
   task automatic tick();
      data_exp = data_in;
      @(negedge clk);
      data_in = {$urandom(), $urandom()};
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b0; frame = 8'h0F; data_in = 64'h1234_5678_9ABC_DEF0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bitslip, locked, data_valid, lock_lost, fail, slip_cnt} !== 9'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected 0", {bitslip, locked, data_valid, lock_lost, fail, slip_cnt});
      end
      checks++;
      if (data_out !== 64'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", data_out); end
      rst_n = 1'b1;
      repeat (4) tick();
      checks++;
      if ({bitslip, locked, slip_cnt} !== 6'd0) begin
         errors++; $display("FAIL idle_after_reset: got %b expected 0", {bitslip, locked, slip_cnt});
      end
   endtask

   // Constant aligned frame: 16 matches after CHECK entry.
   // Counting enable's drive edge as cycle 0, a downstream register first sees lock at edge 18.
   task automatic test_aligned();
      frame = 8'h0F; enable = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         checks++;
         if (bitslip !== 1'b0) begin errors++; $display("FAIL aligned_no_slip: cycle %0d got %b expected 0", i, bitslip); end
         checks++;
         if (data_out !== data_exp) begin errors++; $display("FAIL data_delay: got %h expected %h", data_out, data_exp); end
         if (i == 16) begin
            checks++;
            if (locked !== 1'b0) begin errors++; $display("FAIL early_lock: got %b expected 0", locked); end
         end
         if (i == 17) begin
            checks++;
            if ({locked, data_valid} !== 2'b11) begin errors++; $display("FAIL lock_time: got %b expected 11", {locked, data_valid}); end
         end
      end
      checks++;
      if (slip_cnt !== 4'd0) begin errors++; $display("FAIL aligned_slip_cnt: got %0d expected 0", slip_cnt); end
   endtask

   // Enable falls on the same cycle that the 16th match is sampled: no lock.
   task automatic test_enable_vs_lock();
      enable = 1'b0; tick();
      enable = 1'b1; frame = 8'h0F;
      repeat (16) tick();
      enable = 1'b0;
      tick();
      checks++;
      if ({locked, data_valid} !== 2'b00) begin errors++; $display("FAIL enable_vs_lock: got %b expected 00", {locked, data_valid}); end
      tick();
      checks++;
      if (locked !== 1'b0) begin errors++; $display("FAIL enable_vs_lock_later: got %b expected 0", locked); end
   endtask

   // Deserialiser model: each slip rotates the frame right by one bit.
   task automatic test_rotation();
      int   rot, pulses, last_t;
      logic prev_bs;
      enable = 1'b0; tick();
      rot = 3; frame = rotl8(8'h0F, rot); enable = 1'b1;
      pulses = 0; last_t = -100; prev_bs = 1'b0;
      for (int t = 0; t < 60; t++) begin
         tick();
         if (prev_bs) begin
            checks++;
            if (bitslip !== 1'b0) begin errors++; $display("FAIL slip_width: got %b expected 0", bitslip); end
         end
         if (bitslip === 1'b1) begin
            pulses++;
            if (pulses > 1) begin
               checks++;
               if (t - last_t < 6) begin errors++; $display("FAIL slip_spacing: got %0d expected >=6", t - last_t); end
            end
            last_t = t;
            rot = (rot + 7) % 8;
            frame = rotl8(8'h0F, rot);
         end
         prev_bs = bitslip;
      end
      checks++;
      if (pulses != 3) begin errors++; $display("FAIL rot_pulses: got %0d expected 3", pulses); end
      checks++;
      if (slip_cnt !== 4'd3) begin errors++; $display("FAIL rot_slip_cnt: got %0d expected 3", slip_cnt); end
      checks++;
      if ({locked, fail} !== 2'b10) begin errors++; $display("FAIL rot_lock: got %b expected 10", {locked, fail}); end
   endtask

   // Frame stuck at zero: fail on the 8th slip, count wraps on the 16th.
   // Then enable drops during WAIT, and the search restarts from scratch.
   task automatic test_stuck_and_drop();
      int k;
      enable = 1'b0; tick();
      frame = 8'h00; enable = 1'b1; k = 0;
      for (int t = 0; t < 120 && k < 16; t++) begin
         tick();
         if (bitslip === 1'b1) begin
            k++;
            checks++;
            if (slip_cnt !== k[3:0]) begin errors++; $display("FAIL stuck_slip_cnt: got %0d expected %0d", slip_cnt, k[3:0]); end
            checks++;
            if (fail !== (k >= 8)) begin errors++; $display("FAIL stuck_fail: slip %0d got %b expected %b", k, fail, (k >= 8)); end
         end
      end
      checks++;
      if (k != 16) begin errors++; $display("FAIL stuck_slip_count: got %0d expected 16", k); end
      tick();
      checks++;
      if ({fail, bitslip} !== 2'b10) begin errors++; $display("FAIL fail_sticky: got %b expected 10", {fail, bitslip}); end
      enable = 1'b0;
      tick();
      checks++;
      if ({slip_cnt, fail, bitslip, locked} !== 7'd0) begin
         errors++; $display("FAIL drop_in_wait: got %b expected 0", {slip_cnt, fail, bitslip, locked});
      end
      frame = 8'h0F; enable = 1'b1;
      for (int t = 0; t < 20; t++) begin
         tick();
         checks++;
         if (bitslip !== 1'b0) begin errors++; $display("FAIL reenable_slip: got %b expected 0", bitslip); end
      end
      checks++;
      if ({locked, slip_cnt, fail} !== 6'b1_0000_0) begin
         errors++; $display("FAIL reenable_lock: got %b expected 100000", {locked, slip_cnt, fail});
      end
   endtask

   // While locked: bad frames that do not form a run of 4 are tolerated.
   // Four consecutive bad frames drop the lock.
   task automatic test_lock_loss();
      logic [7:0] pat [9];
      pat = '{8'hF0, 8'h00, 8'hFF, 8'h0F, 8'hE1, 8'h1E, 8'h87, 8'h0F, 8'h0F};
      for (int i = 0; i < 9; i++) begin
         frame = pat[i];
         tick();
         checks++;
         if ({locked, lock_lost} !== 2'b10) begin errors++; $display("FAIL tolerate_miss: step %0d got %b expected 10", i, {locked, lock_lost}); end
      end
      for (int i = 1; i <= 4; i++) begin
         frame = 8'hF0;
         tick();
         checks++;
         if (i < 4 && {locked, lock_lost} !== 2'b10) begin
            errors++; $display("FAIL pre_loss: step %0d got %b expected 10", i, {locked, lock_lost});
         end else if (i == 4 && {lock_lost, locked, data_valid} !== 3'b100) begin
            errors++; $display("FAIL loss_pulse: got %b expected 100", {lock_lost, locked, data_valid});
         end
      end
      tick();
      checks++;
      if ({lock_lost, bitslip, slip_cnt} !== 6'b0_1_0001) begin
         errors++; $display("FAIL resume_search: got %b expected 010001", {lock_lost, bitslip, slip_cnt});
      end
   endtask

   // The lost pulse still fires when enable falls with the 4th miss.
   task automatic test_loss_with_disable();
      frame = 8'h0F;
      repeat (30) tick();
      checks++;
      if (locked !== 1'b1) begin errors++; $display("FAIL relock: got %b expected 1", locked); end
      frame = 8'h3C;
      repeat (3) tick();
      enable = 1'b0;
      tick();
      checks++;
      if ({lock_lost, locked, slip_cnt} !== 6'b1_0_0000) begin
         errors++; $display("FAIL loss_with_disable: got %b expected 100000", {lock_lost, locked, slip_cnt});
      end
      tick();
      checks++;
      if (lock_lost !== 1'b0) begin errors++; $display("FAIL loss_pulse_width: got %b expected 0", lock_lost); end
   endtask

   // Assert reset while locked, and again while a bitslip pulse is high.
   task automatic test_reset_mid();
      frame = 8'h0F; enable = 1'b1;
      repeat (20) tick();
      checks++;
      if (locked !== 1'b1) begin errors++; $display("FAIL pre_reset_lock: got %b expected 1", locked); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bitslip, locked, data_valid, lock_lost, fail, slip_cnt} !== 9'd0 || data_out !== 64'd0) begin
         errors++; $display("FAIL reset_in_lock: got %b data %h expected 0", {bitslip, locked, data_valid, lock_lost, fail, slip_cnt}, data_out);
      end
      enable = 1'b0;
      tick();
      #2 rst_n = 1'b1;
      for (int t = 0; t < 6; t++) begin
         tick();
         checks++;
         if ({bitslip, locked, slip_cnt} !== 6'd0) begin errors++; $display("FAIL idle_hold: got %b expected 0", {bitslip, locked, slip_cnt}); end
      end
      frame = 8'h00; enable = 1'b1;
      tick(); tick();
      checks++;
      if (bitslip !== 1'b1) begin errors++; $display("FAIL slip_before_reset: got %b expected 1", bitslip); end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({bitslip, slip_cnt} !== 5'd0) begin errors++; $display("FAIL reset_in_slip: got %b expected 0", {bitslip, slip_cnt}); end
      enable = 1'b0;
      tick();
      #2 rst_n = 1'b1;
      for (int t = 0; t < 8; t++) begin
         tick();
         checks++;
         if (bitslip !== 1'b0) begin errors++; $display("FAIL no_partial_pulse: got %b expected 0", bitslip); end
      end
      enable = 1'b1;
      tick(); tick();
      checks++;
      if ({bitslip, slip_cnt} !== 5'b1_0001) begin errors++; $display("FAIL fresh_slip: got %b expected 10001", {bitslip, slip_cnt}); end
      tick();
      checks++;
      if (bitslip !== 1'b0) begin errors++; $display("FAIL fresh_slip_width: got %b expected 0", bitslip); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      data_exp = 64'd0;
      test_reset();
      test_aligned();
      test_enable_vs_lock();
      test_rotation();
      test_stuck_and_drop();
      test_lock_loss();
      test_loss_with_disable();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fmc_adc_frame_aligner.md
Name: fmc_adc_frame_aligner

Overview:
- Sits directly upstream of the acquisition core, between the ADC deserialiser (ISERDES on DCO/FR) and the acquisition core's sample input.
- Watches the deserialised frame (FR) word each sample-clock cycle and issues bitslip pulses to the deserialiser until the frame matches the expected pattern.
- Declares lock after a run of consecutive matches, then forwards ADC sample data with a valid flag.
- Detects loss of frame alignment, re-searches automatically, and flags a full-rotation failure to software.

Parameters:
- g_WIDTH, 8: deserialised frame word width; also the number of slips in one full rotation.
- g_FRAME_PATTERN, 8'h0F: expected frame word when aligned.
- g_DATA_WIDTH, 64: sample bus width (4 ch x 16 bit).
- g_LOCK_COUNT, 16: consecutive matches required to lock (>=1).
- g_SLIP_WAIT, 4: cycles to ignore frame_i after a bitslip (deserialiser latency, >=1).
- g_UNLOCK_COUNT, 4: consecutive mismatches in lock that cause loss of lock (>=1).

Ports:
- clk_i  in  1  ADC sample clock (divided DCO).
- rst_n_i  in  1  asynchronous active-low reset.
- enable_i  in  1  alignment enable (from a control register, already synchronised).
- frame_i  in  g_WIDTH  deserialised FR word.
- data_i  in  g_DATA_WIDTH  deserialised sample word.
- bitslip_o  out  1  one-cycle bitslip request to the deserialiser.
- locked_o  out  1  frame aligned.
- data_o  out  g_DATA_WIDTH  registered data_i.
- data_valid_o  out  1  data_o is aligned.
- slip_cnt_o  out  4  bitslips issued since enable; wraps modulo 16.
- lock_lost_o  out  1  one-cycle pulse on loss of lock.
- fail_o  out  1  sticky: g_WIDTH slips issued without achieving lock.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0 (data_o all zeros); all counters 0.
- All outputs are registered. data_o = data_i delayed 1 cycle in every state. data_valid_o is high in the same cycles as locked_o.
- FSM states: IDLE, CHECK, SLIP, WAIT, LOCKED.
- enable_i low in any state: IDLE next cycle. locked_o, bitslip_o, fail_o, slip_cnt_o and all counters are cleared. Priority over every other transition.
- IDLE: enable_i=1 -> CHECK; match_cnt = 0, attempt_cnt = 0.
- CHECK:
  - frame_i == g_FRAME_PATTERN: increment match_cnt.
  - On the g_LOCK_COUNT-th consecutive match -> LOCKED. locked_o rises the cycle after that match is sampled.
  - Mismatch -> SLIP; match_cnt = 0.
- SLIP (exactly 1 cycle):
  - bitslip_o = 1; slip_cnt_o += 1; attempt_cnt += 1.
  - If attempt_cnt reaches g_WIDTH: set fail_o and clear attempt_cnt. Searching continues.
  - Next state WAIT.
- WAIT: frame_i ignored for g_SLIP_WAIT cycles, then CHECK. Consecutive bitslip pulses are therefore separated by at least g_SLIP_WAIT+1 low cycles.
- LOCKED:
  - locked_o = 1; attempt_cnt = 0. fail_o stays set once set, until enable_i goes low.
  - A mismatch increments miss_cnt; a match clears it.
  - When miss_cnt reaches g_UNLOCK_COUNT: lock_lost_o pulses 1 cycle, locked_o and data_valid_o drop in that same cycle, state -> CHECK with match_cnt = 0.
- Simultaneous events: a CHECK match that completes lock while enable_i falls -> IDLE, no lock. The mismatch that reaches g_UNLOCK_COUNT still produces the lock_lost_o pulse even if enable_i falls in the same cycle.
- Reset asserted mid-operation (e.g. during SLIP): bitslip_o drops immediately (asynchronous); no partial pulse after release.

Test Plan:
- Aligned input: frame_i=0x0F constant, enable_i rises at cycle 0 -> bitslip_o never high; locked_o and data_valid_o high at cycle 18; data_o tracks data_i with 1-cycle delay.
- Deserialiser model rotates frame one bit per bitslip, initial 0x0F rotated by 3 -> exactly 3 bitslip pulses, each 1 cycle wide, spaced >=5 cycles apart; slip_cnt_o=3; locked_o high; fail_o=0.
- frame_i stuck at 0x00 -> fail_o set on the 8th bitslip; slips continue; slip_cnt_o wraps 15 -> 0 on the 16th slip.
- In lock, inject 3 bad frames, 1 good, 3 bad -> no loss of lock. Then 4 consecutive bad -> lock_lost_o single-cycle pulse, locked_o=0, search resumes.
- enable_i dropped during WAIT -> IDLE next cycle, slip_cnt_o=0, fail_o=0. Re-enable -> fresh search.
- rst_n_i asserted while LOCKED and during a bitslip pulse -> all outputs 0 immediately; after release, stay IDLE until enable_i is seen high.
